fp_align: RTL and testbench
===========================

# fp_align

Iterative exponent-alignment stage of the parametrisable floating-point unit. Accepts two unsigned operand magnitudes over a valid/ready handshake, brings them to a common exponent by right-shifting the smaller operand up to STEP bits per cycle, and keeps guard and sticky bits for downstream rounding. Handles subnormals and clamps large exponent differences. Sits between operand unpack and the fraction adder.

## Interface
- SIZE, 64, total float width including sign
- EXPONENT, 5 + ($clog2(SIZE)-4)*3, exponent field width
- FRACTION, SIZE-EXPONENT-1, stored fraction width
- STEP, 4, max shift per cycle; power of two, 1 ≤ STEP ≤ FRACTION+3
- W (localparam), FRACTION+4, aligned fraction width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- i_valid  in  1  operands valid
- o_ready  out  1  block can accept operands
- i_A, i_B  in  SIZE-1  {exponent, fraction} magnitudes; sign excluded
- o_valid  out  1  aligned result valid
- i_ready  in  1  consumer accepts result
- o_exp  out  EXPONENT  common (larger effective) exponent
- o_frct_A, o_frct_B  out  W  aligned fractions
- o_swap  out  1  1 when B's effective exponent > A's, i.e. A was shifted

## Operation
- Vector layout, bit W-1 down to 0: carry headroom (always 0 at output), hidden bit, FRACTION fraction bits, guard, sticky.
- Unpack: exponent field ≠ 0 → hidden = 1, effective exponent = field. Field = 0 → hidden = 0, effective exponent = 1. All-ones exponent receives no special treatment.
- FSM states IDLE, ALIGN, DONE; o_ready = (state == IDLE); o_valid = (state == DONE).
- IDLE: on i_valid, load both vectors with guard = sticky = 0, latch o_exp = max effective exponent and o_swap, and set remaining = min(|expA − expB|, W−1). Go to DONE if remaining = 0, else ALIGN.
- ALIGN: per cycle, shift amount s = min(STEP, remaining); smaller vector v' = v >> s with v'[0] = |v[s:0]; remaining -= s. Go to DONE when remaining reaches 0. Larger operand is untouched.
- Clamp: a difference ≥ W−1 shifts every set bit into sticky. Result is 1 if the operand was nonzero, else 0.
- DONE: hold all outputs stable until i_ready; then go to IDLE.
- i_valid while not in IDLE is ignored; the operands are not captured.
- Equal exponents: o_swap = 0, no shift.

## Timing
- Latency from accept edge to first o_valid cycle: 1 + ceil(min(d, W−1)/STEP) cycles.
- d = 0 → o_valid in the cycle after accept.
- Result leaves on the edge with o_valid & i_ready. o_ready rises in the next cycle, so there is one bubble per transaction.
- Reset values: state IDLE, o_ready 1, o_valid 0, o_exp 0, o_frct_A/B 0, o_swap 0.
- Reset asserted mid-ALIGN or mid-DONE aborts immediately with no output; the pending result is lost.

## Structure
- Package fp_pkg: EXPONENT/FRACTION/BIAS derivation functions, state typedef enum {IDLE, ALIGN, DONE}, layout bit-index constants (HIDDEN_BIT, GUARD_BIT, STICKY_BIT).
- Sub-module fp_sticky_shr: combinational right shift of a W-bit vector by 0..STEP with sticky OR-merge; instantiated once on the smaller operand's path.
- Remaining-shift counter width $clog2(W).

## Test plan
All at SIZE=32 (EXPONENT=8, FRACTION=23, W=27), STEP=4.
- A=B=0x3F800000 (1.0) → latency 1, o_exp=127, o_frct_A=o_frct_B=0x2000000, o_swap=0.
- A exp 130, B exp 127, both fractions 0 → latency 2, o_exp=130, o_frct_A=0x2000000, o_frct_B=0x0400000, o_swap=0.
- A exp 127, B exp 137, fractions 0 → latency 4, o_swap=1, o_frct_A=0x0008000, o_frct_B=0x2000000.
- A exp 150, B exp 127 frac 0x000001 → latency 7, o_frct_B=0x0000005 (shifted hidden bit plus sticky). Then A exp 200, B exp 1 frac 0 → latency 8, o_frct_B=0x0000001.
- Subnormal: A exp 1 frac 0, B exp 0 frac 0x400000 → latency 1, o_exp=1, o_frct_A=0x2000000, o_frct_B=0x1000000.
- Handshake/reset: hold i_ready=0 for 3 cycles in DONE with i_valid pulsing → outputs stable, no capture, o_ready=0. Assert i_rst_n=0 mid-ALIGN → o_valid=0, o_ready=1 immediately, all data outputs 0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point alignment path.
// Field-width derivation, FSM states and vector layout indices.
package fp_pkg;

  function automatic int exp_w(input int size);
    return 5 + ($clog2(size) - 4) * 3;
  endfunction

  function automatic int frac_w(input int size);
    return size - exp_w(size) - 1;
  endfunction

  function automatic int bias(input int size);
    return (1 << (exp_w(size) - 1)) - 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    DONE
  } state_t;

  localparam int STICKY_BIT = 0;
  localparam int GUARD_BIT  = 1;

  function automatic int hidden_bit(input int frac);
    return frac + 2;
  endfunction

endpackage

// File: rtl/fp_align_if.sv
// Operand/result handshake bundle of the alignment stage.
// slave = alignment stage, master = producer/consumer side.
interface fp_align_if
  import fp_pkg::*;
#(
  parameter int SIZE = 64
);
  localparam int EXPONENT = exp_w(SIZE);
  localparam int FRACTION = frac_w(SIZE);
  localparam int W        = FRACTION + 4;

  logic                i_valid;
  logic                o_ready;
  logic [SIZE-2:0]     i_A;
  logic [SIZE-2:0]     i_B;
  logic                o_valid;
  logic                i_ready;
  logic [EXPONENT-1:0] o_exp;
  logic [W-1:0]        o_frct_A;
  logic [W-1:0]        o_frct_B;
  logic                o_swap;

  modport master (
    output i_valid, i_A, i_B, i_ready,
    input  o_ready, o_valid, o_exp,
    input  o_frct_A, o_frct_B, o_swap
  );

  modport slave (
    input  i_valid, i_A, i_B, i_ready,
    output o_ready, o_valid, o_exp,
    output o_frct_A, o_frct_B, o_swap
  );
endinterface

// File: rtl/fp_sticky_shr.sv
// Right shift by 0..STEP; every bit shifted out of
// the vector is OR-folded into the sticky LSB.
module fp_sticky_shr #(
  parameter int W    = 27,
  parameter int STEP = 4,
  parameter int SW   = $clog2(STEP + 1)
) (
  input  logic [W-1:0]  i_v,
  input  logic [SW-1:0] i_s,
  output logic [W-1:0]  o_v
);

  // select the k-bit shift and fold bits k..0 into bit 0
  always_comb begin
    o_v = i_v;
    for (int k = 1; k <= STEP; k++) begin
      if (i_s == SW'(k)) begin
        o_v    = i_v >> k;
        o_v[0] = |(i_v & ((W'(1) << (k + 1)) - W'(1)));
      end
    end
  end

endmodule

// File: rtl/fp_align.sv
// Iterative exponent alignment: shifts the smaller operand
// right by up to STEP bits per cycle, keeping guard/sticky.
module fp_align
  import fp_pkg::*;
#(
  parameter int SIZE = 64,
  parameter int STEP = 4
) (
  input logic      i_clk,
  input logic      i_rst_n,
  fp_align_if.slave bus
);

  localparam int EXPONENT = exp_w(SIZE);
  localparam int FRACTION = frac_w(SIZE);
  localparam int W        = FRACTION + 4;
  localparam int RW       = $clog2(W);
  localparam int SW       = $clog2(STEP + 1);

  state_t              state_q, state_d;
  logic [RW-1:0]       rem_q;
  logic [EXPONENT-1:0] exp_q;
  logic [W-1:0]        fa_q, fb_q;
  logic                swap_q;

  logic [EXPONENT-1:0] fe_a, fe_b, ee_a, ee_b, diff;
  logic                swap_c;
  logic [RW-1:0]       rem_c;
  logic [W-1:0]        va, vb, sm, sm_sh;
  logic [SW-1:0]       s;

  assign fe_a = bus.i_A[SIZE-2:FRACTION];
  assign fe_b = bus.i_B[SIZE-2:FRACTION];

  // unpack: subnormals behave as exponent 1 with no hidden bit
  always_comb begin
    ee_a   = (fe_a == '0) ? EXPONENT'(1) : fe_a;
    ee_b   = (fe_b == '0) ? EXPONENT'(1) : fe_b;
    swap_c = ee_b > ee_a;
    diff   = swap_c ? ee_b - ee_a : ee_a - ee_b;
    rem_c  = (32'(diff) >= W - 1) ? RW'(W - 1) : RW'(diff);
    va     = {1'b0, |fe_a, bus.i_A[FRACTION-1:0], 2'b00};
    vb     = {1'b0, |fe_b, bus.i_B[FRACTION-1:0], 2'b00};
  end

  assign sm = swap_q ? fa_q : fb_q;
  assign s  = (rem_q >= RW'(STEP)) ? SW'(STEP) : SW'(rem_q);

  fp_sticky_shr #(
    .W    (W),
    .STEP (STEP),
    .SW   (SW)
  ) u_shr (
    .i_v (sm),
    .i_s (s),
    .o_v (sm_sh)
  );

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (bus.i_valid)
          state_d = (rem_c == '0) ? DONE : ALIGN;
      ALIGN:
        if (rem_q <= RW'(STEP)) state_d = DONE;
      DONE:
        if (bus.i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // operand capture and per-cycle shift of the smaller vector
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem_q  <= '0;
      exp_q  <= '0;
      fa_q   <= '0;
      fb_q   <= '0;
      swap_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE:
          if (bus.i_valid) begin
            rem_q  <= rem_c;
            exp_q  <= swap_c ? ee_b : ee_a;
            fa_q   <= va;
            fb_q   <= vb;
            swap_q <= swap_c;
          end
        ALIGN: begin
          if (swap_q) fa_q <= sm_sh;
          else        fb_q <= sm_sh;
          rem_q <= rem_q - RW'(s);
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready  = (state_q == IDLE);
  assign bus.o_valid  = (state_q == DONE);
  assign bus.o_exp    = exp_q;
  assign bus.o_frct_A = fa_q;
  assign bus.o_frct_B = fb_q;
  assign bus.o_swap   = swap_q;

endmodule

// File: tb/tb_fp_align.sv
// Randomized bench for fp_align at SIZE=32, STEP=4 with a
// single-shift reference model of the alignment result.
module tb_fp_align;

  localparam int SIZE = 32;
  localparam int STEP = 4;
  localparam int W    = 27;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fp_align_if #(.SIZE(SIZE)) bus ();

  fp_align #(
    .SIZE (SIZE),
    .STEP (STEP)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model(input  logic [30:0] a,
                       input  logic [30:0] b,
                       output logic [7:0]  e,
                       output logic [26:0] fa,
                       output logic [26:0] fb,
                       output logic        sw,
                       output int          lat);
    int ea, eb, d;
    logic [63:0] va, vb, sm, r;
    ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
    va = (a[30:23] != 0 ? 64'h2000000 : 64'h0) | (64'(a[22:0]) << 2);
    vb = (b[30:23] != 0 ? 64'h2000000 : 64'h0) | (64'(b[22:0]) << 2);
    sw = eb > ea;
    e  = 8'(sw ? eb : ea);
    d  = sw ? eb - ea : ea - eb;
    if (d > W - 1) d = W - 1;
    sm = sw ? va : vb;
    r  = sm >> d;
    r[0] = |(sm & ((64'd1 << (d + 1)) - 64'd1));
    fa  = sw ? r[26:0] : va[26:0];
    fb  = sw ? vb[26:0] : r[26:0];
    lat = 1 + (d + STEP - 1) / STEP;
  endtask

  task automatic xact(input logic [30:0] a,
                      input logic [30:0] b,
                      input int hold);
    logic [7:0]  e;
    logic [26:0] fa, fb;
    logic        sw;
    int          elat, lat;
    model(a, b, e, fa, fb, sw, elat);
    chk("ready_idle", 64'(bus.o_ready), 64'd1);
    bus.i_valid = 1'b1;
    bus.i_A     = a;
    bus.i_B     = b;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    lat = 1;
    while (!bus.o_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(elat));
    chk("exp", 64'(bus.o_exp), 64'(e));
    chk("frct_A", 64'(bus.o_frct_A), 64'(fa));
    chk("frct_B", 64'(bus.o_frct_B), 64'(fb));
    chk("swap", 64'(bus.o_swap), 64'(sw));
    chk("ready_busy", 64'(bus.o_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      bus.i_valid = 1'b1;
      bus.i_A     = 31'($urandom);
      bus.i_B     = 31'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", 64'(bus.o_valid), 64'd1);
      chk("hold_ready", 64'(bus.o_ready), 64'd0);
      chk("hold_exp", 64'(bus.o_exp), 64'(e));
      chk("hold_A", 64'(bus.o_frct_A), 64'(fa));
      chk("hold_B", 64'(bus.o_frct_B), 64'(fb));
      chk("hold_swap", 64'(bus.o_swap), 64'(sw));
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    chk("leave_valid", 64'(bus.o_valid), 64'd0);
    chk("leave_ready", 64'(bus.o_ready), 64'd1);
  endtask

  function automatic logic [30:0] rnd_near(input logic [30:0] a);
    int e;
    e = int'(a[30:23]) + int'($urandom_range(0, 40)) - 20;
    if (e < 0)   e = 0;
    if (e > 255) e = 255;
    return {8'(e), 23'($urandom)};
  endfunction

  initial begin
    logic [30:0] a, b;
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_A     = '0;
    bus.i_B     = '0;
    #12;
    chk("rst_ready", 64'(bus.o_ready), 64'd1);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_exp", 64'(bus.o_exp), 64'd0);
    chk("rst_A", 64'(bus.o_frct_A), 64'd0);
    chk("rst_B", 64'(bus.o_frct_B), 64'd0);
    chk("rst_swap", 64'(bus.o_swap), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    xact(31'h3F800000, 31'h3F800000, 0);
    xact(31'h41000000, 31'h3F800000, 0);
    xact(31'h3F800000, 31'h44800000, 0);
    xact(31'h4B000000, 31'h3F800001, 0);
    xact(31'h64000000, 31'h00800000, 0);
    xact(31'h00800000, 31'h00400000, 0);
    xact(31'h3F800000, 31'h40000000, 3);
    xact(31'h00000000, 31'h7F800000, 1);

    bus.i_valid = 1'b1;
    bus.i_A     = 31'h64000000;
    bus.i_B     = 31'h00800000;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.o_valid), 64'd0);
    chk("arst_ready", 64'(bus.o_ready), 64'd1);
    chk("arst_exp", 64'(bus.o_exp), 64'd0);
    chk("arst_A", 64'(bus.o_frct_A), 64'd0);
    chk("arst_B", 64'(bus.o_frct_B), 64'd0);
    chk("arst_swap", 64'(bus.o_swap), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 200; i++) begin
      a = 31'($urandom);
      if ($urandom_range(0, 3) == 0) a[30:23] = 8'($urandom_range(0, 2));
      b = ($urandom_range(0, 1) == 0) ? rnd_near(a) : 31'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      xact(a, b, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
